// File: rtl/register_write_arbiter_if.sv
// Register-file write arbitration: shared types plus the requester/register-file bundle.
// Enum widths here define the register-file select and op encodings used on both sides.
package register_write_arbiter_pkg;
    typedef enum logic [1:0] {
        REG_A = 2'd0,
        REG_B = 2'd1,
        REG_C = 2'd2,
        REG_D = 2'd3
    } register_sel_e;

    typedef enum logic {
        REG_READ  = 1'b0,
        REG_WRITE = 1'b1
    } registers_op_e;
endpackage

interface register_write_arbiter_if
    import register_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_BUS_WIDTH = 8
);
    logic                      req0_valid;
    logic                      req0_ready;
    register_sel_e             req0_sel;
    logic [DATA_BUS_WIDTH-1:0] req0_data;
    logic                      req0_lock;

    logic                      req1_valid;
    logic                      req1_ready;
    register_sel_e             req1_sel;
    logic [DATA_BUS_WIDTH-1:0] req1_data;
    logic                      req1_lock;

    registers_op_e             op;
    register_sel_e             reg_in_sel;
    logic [DATA_BUS_WIDTH-1:0] reg_data_in;
    logic                      busy;

    // Requesters plus register-file observer.
    modport master (
        output req0_valid, req0_sel, req0_data, req0_lock,
        output req1_valid, req1_sel, req1_data, req1_lock,
        input  req0_ready, req1_ready,
        input  op, reg_in_sel, reg_data_in, busy
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_sel, req0_data, req0_lock,
        input  req1_valid, req1_sel, req1_data, req1_lock,
        output req0_ready, req1_ready,
        output op, reg_in_sel, reg_data_in, busy
    );
endinterface

// File: rtl/register_write_arbiter.sv
// Two-requester round-robin/locking arbiter for the register file's single write port.
// Optional feature: define REGARB_ROUND_ROBIN_EN for round-robin tie-break (else fixed priority to req0).
module register_write_arbiter
    import register_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_BUS_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    register_write_arbiter_if.slave   bus
);
    localparam int unsigned DW = DATA_BUS_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          busy_q, busy_d;
    registers_op_e op_q, op_d;
    register_sel_e sel_q, sel_d;
    logic [DW-1:0] data_q, data_d;
    logic          grant0_c, grant1_c;
    logic          tie0_c;

`ifdef REGARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    // Requester 0 wins a tie only if requester 1 was granted last.
    assign tie0_c = last_grant_q;

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant0_c)      last_grant_d = 1'b0;
        else if (grant1_c) last_grant_d = 1'b1;
    end
`else
    assign tie0_c = 1'b1;
`endif

    // Grant selection, next FSM state and write-stage load.
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        state_d  = state_q;
        busy_d   = 1'b0;
        op_d     = REG_READ;
        sel_d    = sel_q;
        data_d   = data_q;

        case (state_q)
            IDLE: begin
                grant0_c = bus.req0_valid && (!bus.req1_valid || tie0_c);
                grant1_c = bus.req1_valid && !grant0_c;
            end
            LOCK0:   grant0_c = bus.req0_valid;
            LOCK1:   grant1_c = bus.req1_valid;
            default: ;
        endcase

        if (grant0_c) begin
            busy_d  = 1'b1;
            op_d    = REG_WRITE;
            sel_d   = bus.req0_sel;
            data_d  = bus.req0_data;
            state_d = bus.req0_lock ? LOCK0 : IDLE;
        end else if (grant1_c) begin
            busy_d  = 1'b1;
            op_d    = REG_WRITE;
            sel_d   = bus.req1_sel;
            data_d  = bus.req1_data;
            state_d = bus.req1_lock ? LOCK1 : IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            op_q         <= REG_READ;
            sel_q        <= REG_A;
            data_q       <= DW'(0);
`ifdef REGARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            op_q         <= op_d;
            sel_q        <= sel_d;
            data_q       <= data_d;
`ifdef REGARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign bus.req0_ready  = grant0_c;
    assign bus.req1_ready  = grant1_c;
    assign bus.op          = op_q;
    assign bus.reg_in_sel  = sel_q;
    assign bus.reg_data_in = data_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_register_write_arbiter.sv
// Randomized + directed bench for register_write_arbiter with a queue-based scoreboard.
module tb_register_write_arbiter;
    import register_write_arbiter_pkg::*;

    typedef struct {
        int            gap;
        register_sel_e sel;
        logic [7:0]    data;
        logic          lock;
    } beat_t;

    typedef struct {
        register_sel_e sel;
        logic [7:0]    data;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    register_write_arbiter_if #(.DATA_BUS_WIDTH(8)) bus ();

    register_write_arbiter #(.DATA_BUS_WIDTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    beat_t sq0[$];
    beat_t sq1[$];
    exp_t  expq[$];
    int    grant_log[$];

    logic  vld[2];
    beat_t cur[2];
    logic  acc[2];
    int    owner = -1;
    int    last  = 1;
    register_sel_e last_sel  = REG_A;
    logic [7:0]    last_data = 8'h00;

    task automatic check(input bit ok, input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push(input int n, input int gap, input int sel, input logic [7:0] data, input logic lock);
        beat_t b;
        b.gap  = gap;
        b.sel  = register_sel_e'(2'(sel));
        b.data = data;
        b.lock = lock;
        if (n == 0) sq0.push_back(b);
        else        sq1.push_back(b);
    endtask

    // Present queued beats; hold each until the model says it was accepted.
    task automatic drive();
        beat_t b;
        if (acc[0]) vld[0] = 1'b0;
        if (acc[1]) vld[1] = 1'b0;
        if (!vld[0] && sq0.size() > 0) begin
            b = sq0[0];
            if (b.gap > 0) begin b.gap--; sq0[0] = b; end
            else begin cur[0] = sq0.pop_front(); vld[0] = 1'b1; end
        end
        if (!vld[1] && sq1.size() > 0) begin
            b = sq1[0];
            if (b.gap > 0) begin b.gap--; sq1[0] = b; end
            else begin cur[1] = sq1.pop_front(); vld[1] = 1'b1; end
        end
        bus.req0_valid = vld[0];
        bus.req0_sel   = vld[0] ? cur[0].sel  : register_sel_e'(2'($urandom));
        bus.req0_data  = vld[0] ? cur[0].data : 8'($urandom);
        bus.req0_lock  = vld[0] ? cur[0].lock : 1'($urandom);
        bus.req1_valid = vld[1];
        bus.req1_sel   = vld[1] ? cur[1].sel  : register_sel_e'(2'($urandom));
        bus.req1_data  = vld[1] ? cur[1].data : 8'($urandom);
        bus.req1_lock  = vld[1] ? cur[1].lock : 1'($urandom);
    endtask

    // Reference arbitration: lock owner first, else tie-break rule, else the lone requester.
    task automatic model();
        int   g;
        exp_t e;
        g = -1;
        if (!reset) begin
            owner  = -1;
            last   = 1;
            acc[0] = 1'b0;
            acc[1] = 1'b0;
            return;
        end
        if (owner >= 0) begin
            if (vld[owner]) g = owner;
        end else if (vld[0] && vld[1]) begin
`ifdef REGARB_ROUND_ROBIN_EN
            g = (last == 1) ? 0 : 1;
`else
            g = 0;
`endif
        end else if (vld[0]) g = 0;
        else if (vld[1]) g = 1;
        check(bus.req0_ready === (g == 0) && bus.req1_ready === (g == 1), "ready",
              {30'd0, bus.req1_ready, bus.req0_ready}, {30'd0, g == 1, g == 0});
        acc[0] = (g == 0);
        acc[1] = (g == 1);
        if (g >= 0) begin
            e.sel  = cur[g].sel;
            e.data = cur[g].data;
            expq.push_back(e);
            grant_log.push_back(g);
            last  = g;
            owner = cur[g].lock ? g : -1;
        end
    endtask

    initial begin
        vld[0] = 1'b0; vld[1] = 1'b0;
        acc[0] = 1'b0; acc[1] = 1'b0;
        drive();
        forever begin
            @(posedge clock);
            #2 drive();
            @(negedge clock);
            model();
        end
    end

    // Scoreboard monitor: write stage sampled just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (!reset) begin
                last_sel  = REG_A;
                last_data = 8'h00;
            end else if (bus.busy) begin
                if (expq.size() == 0) begin
                    check(1'b0, "unexpected_write", {24'd0, bus.reg_data_in}, 32'd0);
                end else begin
                    e = expq.pop_front();
                    check(bus.op === REG_WRITE && bus.reg_in_sel === e.sel && bus.reg_data_in === e.data,
                          "write_beat", {23'd0, bus.op, 6'd0, bus.reg_in_sel, bus.reg_data_in},
                          {23'd0, REG_WRITE, 6'd0, e.sel, e.data});
                    last_sel  = e.sel;
                    last_data = e.data;
                end
            end else begin
                check(bus.op === REG_READ && expq.size() == 0 && bus.reg_in_sel === last_sel
                      && bus.reg_data_in === last_data, "idle_stage",
                      {23'd0, bus.op, 6'd0, bus.reg_in_sel, bus.reg_data_in},
                      {23'd0, REG_READ, 6'd0, last_sel, last_data});
            end
        end
    end

    task automatic drain(input int max_cycles);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(posedge clock);
            #3;
            if (sq0.size() == 0 && sq1.size() == 0 && !vld[0] && !vld[1] && expq.size() == 0) done = 1'b1;
        end
        if (!done) check(1'b0, "drain_timeout", 32'(expq.size()), 32'd0);
        @(posedge clock);
    endtask

    task automatic check_log(input string name, input int exp_order[$]);
        check(grant_log.size() >= exp_order.size(), {name, "_len"}, 32'(grant_log.size()), 32'(exp_order.size()));
        for (int i = 0; i < exp_order.size() && i < grant_log.size(); i++)
            check(grant_log[i] == exp_order[i], name, 32'(grant_log[i]), 32'(exp_order[i]));
    endtask

    initial begin
        int exp_order[$];
        bit seen;

        // Reset values.
        repeat (3) @(posedge clock);
        #3 reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check(bus.op === REG_READ && bus.busy === 1'b0 && bus.req0_ready === 1'b0
                  && bus.req1_ready === 1'b0 && bus.reg_in_sel === REG_A && bus.reg_data_in === 8'h00,
                  "reset_values", {28'd0, bus.op, bus.busy, bus.req0_ready, bus.req1_ready}, 32'd0);
        end

        // Continuous tie from reset.
        grant_log.delete();
        for (int i = 0; i < 6; i++) begin
            push(0, 0, i % 4, 8'(8'h40 + i), 1'b0);
            push(1, 0, (i + 1) % 4, 8'(8'h80 + i), 1'b0);
        end
        drain(100);
`ifdef REGARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0, 0, 0};
`endif
        check_log("tie_order", exp_order);

        // Single write.
        push(0, 0, 2, 8'hA5, 1'b0);
        drain(50);

        // Lock burst from req1 while req0 waits.
        grant_log.delete();
        push(1, 0, 1, 8'hB1, 1'b1);
        push(1, 0, 2, 8'hB2, 1'b1);
        push(1, 0, 3, 8'hB3, 1'b0);
        push(0, 1, 0, 8'hC0, 1'b0);
        drain(50);
        exp_order = '{1, 1, 1, 0};
        check_log("lock_order", exp_order);

        // Same register back to back.
        grant_log.delete();
        push(0, 0, 3, 8'h11, 1'b0);
        push(1, 1, 3, 8'h22, 1'b0);
        drain(50);
        exp_order = '{0, 1};
        check_log("same_reg_order", exp_order);

        // Randomized traffic; every requester ends its stream unlocked.
        for (int n = 0; n < 2; n++)
            for (int i = 0; i < 200; i++)
                push(n, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 8'($urandom),
                     (i == 199) ? 1'b0 : ($urandom_range(0, 3) == 0));
        drain(5000);

        // Reset while a locking beat sits in the stage.
        push(0, 0, 1, 8'hFF, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clock);
            #1;
            if (bus.busy) seen = 1'b1;
        end
        check(seen, "busy_before_reset", {31'd0, seen}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check(bus.busy === 1'b0 && bus.op === REG_READ && bus.reg_in_sel === REG_A && bus.reg_data_in === 8'h00,
              "async_reset", {22'd0, bus.busy, bus.op, 6'd0, bus.reg_in_sel, bus.reg_data_in}, 32'd0);
        expq.delete();
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        grant_log.delete();
        push(1, 0, 2, 8'h33, 1'b0);
        drain(50);
        exp_order = '{1};
        check_log("post_reset_unlocked", exp_order);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
